// File: rtl/maquina_cafe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cafe_pkg: shared types, coin values and per-drink tables             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cafe_pkg;

    localparam int CAFE_MONEY_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PAY    = 3'd1,
        ST_SERVE  = 3'd2,
        ST_FINISH = 3'd3,
        ST_REFUND = 3'd4
    } cafe_state_t;

    localparam logic [7:0] C_COIN_SW0 = 8'd1;
    localparam logic [7:0] C_COIN_SW1 = 8'd2;
    localparam logic [7:0] C_COIN_SW2 = 8'd5;
    localparam logic [7:0] C_COIN_SW3 = 8'd10;

    // Indexed by drink number: element [0] is drink0.
    localparam logic [3:0][7:0] C_DRINK_COST  = {8'd12, 8'd10, 8'd8, 8'd5};
    localparam logic [3:0][3:0] C_DRINK_TICKS = {4'd6, 4'd5, 4'd4, 4'd3};

    function automatic logic [7:0] coin_value(input logic [1:0] sw);
        logic [7:0] v;
        case (sw)
            2'd0:    v = C_COIN_SW0;
            2'd1:    v = C_COIN_SW1;
            2'd2:    v = C_COIN_SW2;
            default: v = C_COIN_SW3;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] lowest_set(input logic [3:0] b);
        logic [1:0] idx;
        if (b[0])      idx = 2'd0;
        else if (b[1]) idx = 2'd1;
        else if (b[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maquina_cafe_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maquina_cafe_ctrl_if: user-facing buttons/coins and controller status|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface maquina_cafe_ctrl_if
    import cafe_pkg::*;
#(
    parameter int MONEY_W = CAFE_MONEY_W
);
    logic [3:0]         btn;
    logic               coin_in;
    logic [1:0]         switch;
    logic               cancelar;
    logic [1:0]         sel_drink;
    logic [MONEY_W-1:0] credit;
    logic               serving;
    logic               busy;
    logic [MONEY_W-1:0] change;
    logic               change_valid;
    logic               done;

    modport master (
        output btn, coin_in, switch, cancelar,
        input  sel_drink, credit, serving, busy, change, change_valid, done
    );

    modport slave (
        input  btn, coin_in, switch, cancelar,
        output sel_drink, credit, serving, busy, change, change_valid, done
    );
endinterface
`default_nettype wire

// File: rtl/maquina_cafe_ctrl_serve_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serve_timer: tick prescaler plus serve-tick down-counter             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module serve_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int TIME_W   = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load_i,
    input  wire logic [TIME_W-1:0] ticks_i,
    input  wire logic              enable_i,
    output logic                   expired_o
);
    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  pre_q;
    logic [TIME_W-1:0] cnt_q;
    logic              w_wrap;

    assign w_wrap = (pre_q == C_PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            pre_q <= '0;
            cnt_q <= ticks_i;
        end else if (enable_i) begin
            if (w_wrap) begin
                pre_q <= '0;
                if (cnt_q != '0) cnt_q <= cnt_q - TIME_W'(1);
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

    // Flags the wrap that takes the counter to zero, so the caller leaves
    // SERVE on exactly that edge.
    assign expired_o = enable_i && w_wrap && (cnt_q <= TIME_W'(1));

endmodule
`default_nettype wire

// File: rtl/maquina_cafe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maquina_cafe_ctrl: drink selection, credit, serving and change FSM   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module maquina_cafe_ctrl
    import cafe_pkg::*;
#(
    parameter int MONEY_W  = CAFE_MONEY_W,
    parameter int TICK_DIV = 50_000_000,
    parameter int TIME_W   = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    maquina_cafe_ctrl_if.slave bus
);
    cafe_state_t        state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic [MONEY_W-1:0] change_lat_q, change_lat_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic               busy_q, serving_q, done_q, change_valid_q;

    logic [MONEY_W-1:0] w_cost;
    logic [MONEY_W-1:0] w_coin;
    logic [TIME_W-1:0]  w_ticks;
    logic               w_timer_load;
    logic               w_timer_expired;

    function automatic logic [MONEY_W-1:0] sat_add(input logic [MONEY_W-1:0] a,
                                                   input logic [MONEY_W-1:0] b);
        logic [MONEY_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[MONEY_W] ? '1 : s[MONEY_W-1:0];
    endfunction

    assign w_cost  = MONEY_W'(C_DRINK_COST[sel_q]);
    assign w_ticks = TIME_W'(C_DRINK_TICKS[sel_q]);
    assign w_coin  = bus.coin_in ? MONEY_W'(coin_value(bus.switch)) : '0;

    serve_timer #(
        .TICK_DIV (TICK_DIV),
        .TIME_W   (TIME_W)
    ) u_serve_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (w_timer_load),
        .ticks_i   (w_ticks),
        .enable_i  (state_q == ST_SERVE),
        .expired_o (w_timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        credit_d     = credit_q;
        change_lat_d = change_lat_q;
        w_timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.btn) begin
                    state_d = ST_PAY;
                    sel_d   = lowest_set(bus.btn);
                end
            end
            ST_PAY: begin
                if (bus.cancelar) begin
                    state_d = ST_REFUND;
                end else begin
                    credit_d = sat_add(credit_q, w_coin);
                    // Compare against the registered credit; a coin landing on
                    // the transition edge is folded into the change instead.
                    if (credit_q >= w_cost) begin
                        state_d      = ST_SERVE;
                        change_lat_d = sat_add(credit_q - w_cost, w_coin);
                        w_timer_load = 1'b1;
                    end
                end
            end
            ST_SERVE: begin
                if (w_timer_expired) state_d = ST_FINISH;
            end
            ST_FINISH, ST_REFUND: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        change_d = '0;
        if (state_d == ST_FINISH)      change_d = change_lat_q;
        else if (state_d == ST_REFUND) change_d = credit_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sel_q          <= '0;
            credit_q       <= '0;
            change_lat_q   <= '0;
            change_q       <= '0;
            busy_q         <= 1'b0;
            serving_q      <= 1'b0;
            done_q         <= 1'b0;
            change_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            credit_q       <= credit_d;
            change_lat_q   <= change_lat_d;
            change_q       <= change_d;
            busy_q         <= (state_d != ST_IDLE);
            serving_q      <= (state_d == ST_SERVE);
            done_q         <= (state_d == ST_FINISH);
            change_valid_q <= (state_d == ST_FINISH) || (state_d == ST_REFUND);
        end
    end

    assign bus.sel_drink    = sel_q;
    assign bus.credit       = credit_q;
    assign bus.serving      = serving_q;
    assign bus.busy         = busy_q;
    assign bus.change       = change_q;
    assign bus.change_valid = change_valid_q;
    assign bus.done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_maquina_cafe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_maquina_cafe_ctrl: directed vectors for the coffee controller     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_maquina_cafe_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    maquina_cafe_ctrl_if #(.MONEY_W(8)) bus_a ();
    maquina_cafe_ctrl_if #(.MONEY_W(4)) bus_b ();

    maquina_cafe_ctrl #(.MONEY_W(8), .TICK_DIV(2), .TIME_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    maquina_cafe_ctrl #(.MONEY_W(4), .TICK_DIV(2), .TIME_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin_a(input logic [1:0] sw);
        bus_a.coin_in = 1'b1;
        bus_a.switch  = sw;
        step();
        bus_a.coin_in = 1'b0;
    endtask

    task automatic coin_b(input logic [1:0] sw);
        bus_b.coin_in = 1'b1;
        bus_b.switch  = sw;
        step();
        bus_b.coin_in = 1'b0;
    endtask

    task automatic press_a(input logic [3:0] b);
        bus_a.btn = b;
        step();
        bus_a.btn = 4'b0000;
    endtask

    // Counts sampled cycles with serving high, starting from the current one.
    task automatic serve_len_a(output int n);
        n = 0;
        while (bus_a.serving && n < 60) begin
            n++;
            step();
        end
    endtask

    task automatic serve_len_b(output int n);
        n = 0;
        while (bus_b.serving && n < 60) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus_a.btn = '0; bus_a.coin_in = 1'b0; bus_a.switch = '0; bus_a.cancelar = 1'b0;
        bus_b.btn = '0; bus_b.coin_in = 1'b0; bus_b.switch = '0; bus_b.cancelar = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    32'(bus_a.busy), 0);
        chk("rst_serving", 32'(bus_a.serving), 0);
        chk("rst_credit",  32'(bus_a.credit), 0);
        chk("rst_cv",      32'(bus_a.change_valid), 0);
        chk("rst_done",    32'(bus_a.done), 0);
        rst = 1'b0;
        step();

        // Drink2, coins 10 then 2 (second coin lands on the PAY->SERVE edge).
        press_a(4'b0100);
        chk("d2_busy", 32'(bus_a.busy), 1);
        chk("d2_sel",  32'(bus_a.sel_drink), 2);
        coin_a(2'd3);
        chk("d2_credit10", 32'(bus_a.credit), 10);
        coin_a(2'd1);
        chk("d2_credit12", 32'(bus_a.credit), 12);
        serve_len_a(n);
        chk("d2_serve_len", 32'(n), 10);
        chk("d2_done",   32'(bus_a.done), 1);
        chk("d2_cv",     32'(bus_a.change_valid), 1);
        chk("d2_change", 32'(bus_a.change), 2);
        step();
        chk("d2_done_pulse", 32'(bus_a.done), 0);
        chk("d2_idle_busy",  32'(bus_a.busy), 0);
        chk("d2_idle_credit", 32'(bus_a.credit), 0);

        // Two buttons: lowest index wins; exact payment for drink0.
        press_a(4'b0011);
        chk("d0_sel", 32'(bus_a.sel_drink), 0);
        coin_a(2'd2);
        chk("d0_credit", 32'(bus_a.credit), 5);
        step();
        serve_len_a(n);
        chk("d0_serve_len", 32'(n), 6);
        chk("d0_done",   32'(bus_a.done), 1);
        chk("d0_change", 32'(bus_a.change), 0);
        step();

        // Drink3, cancel with a simultaneous coin.
        press_a(4'b1000);
        chk("cx_sel", 32'(bus_a.sel_drink), 3);
        coin_a(2'd2);
        coin_a(2'd1);
        chk("cx_credit", 32'(bus_a.credit), 7);
        bus_a.cancelar = 1'b1;
        bus_a.coin_in  = 1'b1;
        bus_a.switch   = 2'd3;
        step();
        bus_a.cancelar = 1'b0;
        bus_a.coin_in  = 1'b0;
        chk("cx_cv",     32'(bus_a.change_valid), 1);
        chk("cx_change", 32'(bus_a.change), 7);
        chk("cx_done",   32'(bus_a.done), 0);
        step();
        chk("cx_idle_busy",   32'(bus_a.busy), 0);
        chk("cx_idle_credit", 32'(bus_a.credit), 0);

        // Drink3 paid with 10+5, coin during SERVE ignored.
        press_a(4'b1000);
        coin_a(2'd3);
        coin_a(2'd2);
        chk("d3_credit15", 32'(bus_a.credit), 15);
        step();
        chk("d3_serving", 32'(bus_a.serving), 1);
        coin_a(2'd3);
        chk("d3_coin_ignored", 32'(bus_a.credit), 15);
        serve_len_a(n);
        chk("d3_serve_len_rest", 32'(n), 11);
        chk("d3_done",   32'(bus_a.done), 1);
        chk("d3_change", 32'(bus_a.change), 3);
        step();

        // Asynchronous reset in the middle of SERVE.
        press_a(4'b0100);
        coin_a(2'd3);
        coin_a(2'd1);
        step();
        chk("rs_serving_pre", 32'(bus_a.serving), 1);
        rst = 1'b1;
        #1;
        chk("rs_busy",    32'(bus_a.busy), 0);
        chk("rs_serving", 32'(bus_a.serving), 0);
        chk("rs_credit",  32'(bus_a.credit), 0);
        chk("rs_cv",      32'(bus_a.change_valid), 0);
        #1;
        rst = 1'b0;
        step();
        chk("rs_idle_busy", 32'(bus_a.busy), 0);
        chk("rs_idle_cv",   32'(bus_a.change_valid), 0);

        // Narrow credit: 10+10 saturates at 15, drink3 returns 3.
        bus_b.btn = 4'b1000;
        step();
        bus_b.btn = 4'b0000;
        coin_b(2'd3);
        chk("w4_credit10", 32'(bus_b.credit), 10);
        coin_b(2'd3);
        chk("w4_credit_sat", 32'(bus_b.credit), 15);
        step();
        serve_len_b(n);
        chk("w4_serve_len", 32'(n), 12);
        chk("w4_done",   32'(bus_b.done), 1);
        chk("w4_change", 32'(bus_b.change), 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
